sw_input_ctrl: RTL and testbench

//   Write controller for the switch register (regSW). Synchronises and debounces the raw

---
 rtl/sw_input_ctrl.sv | 116 +++++++++++
 tb/tb_sw_input_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sw_input_ctrl.sv
// Switch register write controller: synchronises and debounces the panel switches,
// pulses a write enable once per stable change, and tracks pending/overrun for the CPU.
module sw_input_ctrl #(
  parameter int SW_W            = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [SW_W-1:0] sw_raw_i,
  input  logic            rd_i,
  output logic            sw_wen_o,
  output logic [SW_W-1:0] sw_d_o,
  output logic            pend_o,
  output logic            ovf_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    COMMIT
  } state_t;

  state_t            state, state_next;
  logic [SW_W-1:0]   sync_a, sync_v;
  logic [SW_W-1:0]   cand, cand_next;
  logic [SW_W-1:0]   cur, cur_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              pend, pend_next;
  logic              ovf, ovf_next;

  // Two-flop synchroniser; nothing downstream ever looks at sw_raw_i directly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_a <= '0;
      sync_v <= '0;
    end else begin
      sync_a <= sw_raw_i;
      sync_v <= sync_a;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cand  <= '0;
      cur   <= '0;
      cnt   <= '0;
      pend  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      cand  <= cand_next;
      cur   <= cur_next;
      cnt   <= cnt_next;
      pend  <= pend_next;
      ovf   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state;
    cand_next  = cand;
    cur_next   = cur;
    cnt_next   = cnt;
    pend_next  = pend;
    ovf_next   = ovf;

    case (state)
      IDLE: begin
        if (sync_v != cur) begin
          cand_next  = sync_v;
          cnt_next   = '0;
          state_next = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (sync_v == cur) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else if (sync_v != cand) begin
          cand_next = sync_v;
          cnt_next  = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = COMMIT;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      COMMIT: begin
        cur_next   = cand;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // A commit coinciding with a read wins: the old value counts as read.
    if (state == COMMIT) begin
      pend_next = 1'b1;
      ovf_next  = rd_i ? 1'b0 : (ovf | pend);
    end else if (rd_i) begin
      pend_next = 1'b0;
      ovf_next  = 1'b0;
    end
  end

  assign sw_wen_o = (state == COMMIT);
  assign sw_d_o   = cand;
  assign pend_o   = pend;
  assign ovf_o    = ovf;

endmodule

// File: tb/tb_sw_input_ctrl.sv
// Bench for sw_input_ctrl: directed scenarios then random switch activity, all checked
// against a run-length model of the debounce rules plus a small regSW stand-in.
module tb_sw_input_ctrl;

  localparam int SW_W = 2;
  localparam int DEB  = 4;

  logic            clk;
  logic            rst_n;
  logic [SW_W-1:0] sw_raw;
  logic            rd;
  logic            sw_wen;
  logic [SW_W-1:0] sw_d;
  logic            pend;
  logic            ovf;
  logic [SW_W-1:0] reg_q;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [SW_W-1:0] m_r1, m_r2, m_cur, m_cand;
  logic            m_commit, m_pend, m_ovf;
  int              m_run;

  int wen_count;
  int wen_step;

  sw_input_ctrl #(.SW_W(SW_W), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .sw_raw_i (sw_raw),
    .rd_i     (rd),
    .sw_wen_o (sw_wen),
    .sw_d_o   (sw_d),
    .pend_o   (pend),
    .ovf_o    (ovf)
  );

  // Stand-in for regSW, sharing the controller's reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) reg_q <= '0;
    else if (sw_wen) reg_q <= sw_d;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_r1 = '0; m_r2 = '0; m_cur = '0; m_cand = '0;
    m_commit = 1'b0; m_pend = 1'b0; m_ovf = 1'b0; m_run = 0;
  endtask

  // A value commits once it has been seen D+1 consecutive times (and differs from the
  // committed copy); the sample taken during the commit cycle itself is ignored.
  task automatic model_edge();
    logic [SW_W-1:0] seen;
    seen = m_r2;
    m_r2 = m_r1;
    m_r1 = sw_raw;
    if (m_commit) begin
      m_cur    = m_cand;
      m_ovf    = rd ? 1'b0 : (m_ovf | m_pend);
      m_pend   = 1'b1;
      m_commit = 1'b0;
      m_run    = 0;
    end else begin
      if (rd) begin
        m_pend = 1'b0;
        m_ovf  = 1'b0;
      end
      if (seen == m_cur) m_run = 0;
      else if (m_run > 0 && seen == m_cand) m_run++;
      else begin
        m_cand = seen;
        m_run  = 1;
      end
      if (m_run == DEB + 1) begin
        m_commit = 1'b1;
        m_run    = 0;
      end
    end
  endtask

  task automatic check_all();
    check_output("wen",  8'(sw_wen), 8'(m_commit));
    check_output("d",    8'(sw_d),   8'(m_cand));
    check_output("pend", 8'(pend),   8'(m_pend));
    check_output("ovf",  8'(ovf),    8'(m_ovf));
    check_output("q",    8'(reg_q),  8'(m_cur));
  endtask

  task automatic apply_stimulus(input logic [SW_W-1:0] v, input logic r);
    @(negedge clk);
    sw_raw = v;
    rd     = r;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (sw_wen) wen_count++;
  endtask

  task automatic hold(input logic [SW_W-1:0] v, input int n);
    for (int i = 0; i < n; i++) apply_stimulus(v, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_output("rst_wen",  8'(sw_wen), 8'h0);
    check_output("rst_d",    8'(sw_d),   8'h0);
    check_output("rst_pend", 8'(pend),   8'h0);
    check_output("rst_ovf",  8'(ovf),    8'h0);
    sw_raw = '0;
    rd     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    sw_raw = '0;
    rd     = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_all();

    // Reset in the middle of a debounce must abort it without any write.
    hold(2'b01, 4);
    do_reset();
    wen_count = 0;
    hold(2'b00, 20);
    check_output("t1_no_wen", 8'(wen_count), 8'd0);

    // Clean change: the pulse lands in the 7th step after the first sampling edge.
    wen_count = 0;
    wen_step  = 0;
    for (int i = 1; i <= 10; i++) begin
      apply_stimulus(2'b11, 1'b0);
      if (sw_wen && wen_step == 0) wen_step = i;
    end
    check_output("t2_pulses", 8'(wen_count), 8'd1);
    check_output("t2_step",   8'(wen_step),  8'd7);
    check_output("t2_q",      8'(reg_q),     8'h3);
    check_output("t2_pend",   8'(pend),      8'h1);

    // Bounce, then a held value.
    do_reset();
    wen_count = 0;
    hold(2'b01, 3);
    hold(2'b00, 8);
    check_output("t3_bounce", 8'(wen_count), 8'd0);
    hold(2'b01, 10);
    check_output("t3_pulses", 8'(wen_count), 8'd1);
    check_output("t3_q",      8'(reg_q),     8'h1);

    // Candidate restart: 01 never gets written.
    do_reset();
    wen_count = 0;
    hold(2'b01, 3);
    hold(2'b10, 12);
    check_output("t4_pulses", 8'(wen_count), 8'd1);
    check_output("t4_q",      8'(reg_q),     8'h2);

    // Overrun, then a read clears both flags.
    do_reset();
    hold(2'b11, 10);
    hold(2'b01, 10);
    check_output("t5_ovf",  8'(ovf),  8'h1);
    check_output("t5_pend", 8'(pend), 8'h1);
    apply_stimulus(2'b01, 1'b1);
    apply_stimulus(2'b01, 1'b0);
    check_output("t5_rd_ovf",  8'(ovf),  8'h0);
    check_output("t5_rd_pend", 8'(pend), 8'h0);

    // Collision: read strobe during the commit cycle while a value is pending.
    hold(2'b10, 10);
    for (int i = 0; i < 10; i++) apply_stimulus(2'b11, m_commit);
    check_output("t6_pend", 8'(pend), 8'h1);
    check_output("t6_ovf",  8'(ovf),  8'h0);

    // Random switch activity with sporadic reads.
    for (int i = 0; i < 300; i++) begin
      logic [SW_W-1:0] v;
      int len;
      v   = SW_W'($urandom_range(0, 3));
      len = $urandom_range(1, 8);
      for (int j = 0; j < len; j++) apply_stimulus(v, ($urandom_range(0, 5) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
